// File: rtl/raster_dispatch.sv
// Triangle dispatch buffer: queues packed triangle words and issues them to the
// rasterize core one at a time, modelling core occupancy with a bounding-box countdown.
module raster_dispatch #(
  parameter int DEPTH = 8,
  parameter int SLACK = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [63:0]              s_tri,
  output logic                     r_valid,
  output logic [63:0]              r_tri,
  output logic                     busy,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [13:0]     cnt_q, cnt_d;
  logic [63:0]     r_tri_q, r_tri_d;
  logic [15:0]     issued_q, issued_d;
  logic            push, pop;
  logic [63:0]     head;
  logic [6:0]      bb_w, bb_h;
  logic [13:0]     area, load;

  // Extent of three signed 6-bit coordinates, inclusive: 1..64.
  function automatic logic [6:0] span(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c);
    logic signed [6:0] sa, sb, sc, mx, mn;
    logic [6:0] diff;
    sa = signed'({a[5], a});
    sb = signed'({b[5], b});
    sc = signed'({c[5], c});
    mx = sa;
    mn = sa;
    if (sb > mx) mx = sb;
    if (sc > mx) mx = sc;
    if (sb < mn) mn = sb;
    if (sc < mn) mn = sc;
    diff = mx - mn;
    return diff + 7'd1;
  endfunction

  // ---------------------------------------------------------------- FIFO
  assign s_ready    = (count_q < CW'(DEPTH));
  assign push       = s_valid && s_ready && !flush;
  assign pop        = r_valid;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the triangle storage carries no reset; occupancy is tracked by count_q and
  // the pointers, so stale words are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tri;
  end

  // NOTE: every sequential process uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ------------------------------------------------------ occupancy window
  assign bb_w = span(head[63:58], head[45:40], head[27:22]);
  assign bb_h = span(head[57:52], head[39:34], head[21:16]);
  assign area = {7'd0, bb_w} * {7'd0, bb_h};
  assign load = area + 14'(SLACK);
  assign busy = (cnt_q != 14'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (pop)       cnt_d = load;
    else if (busy) cnt_d = cnt_q - 14'd1;
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational block assigns a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pop) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q <= 14'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The core only samples valid_in while idle, so the strobe is gated by the window.
  always_comb begin
    r_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: r_valid = (count_q != '0) && !busy;
      ST_WAIT: r_valid = 1'b0;
      default: r_valid = 1'b0;
    endcase
  end

  // ------------------------------------------------------ issue bookkeeping
  always_comb begin
    r_tri_d  = r_tri_q;
    issued_d = issued_q;
    if (pop) begin
      r_tri_d  = head;
      issued_d = issued_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      r_tri_q  <= '0;
      issued_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      r_tri_q  <= r_tri_d;
      issued_q <= issued_d;
    end
  end

  // The head is visible on the issue cycle itself and held afterwards.
  assign r_tri  = pop ? head : r_tri_q;
  assign issued = issued_q;
  assign idle   = (count_q == '0) && !busy && !r_valid;

endmodule
